// File: rtl/decode_regbank_if.sv
// rtl/decode_regbank_if.sv - decoder/write-back/execute-side bus of the decode register bank
interface decode_regbank_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int NRD  = 3
);
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD-1:0]      rd_bank;
    logic [NRD*XLEN-1:0] rd_data;
    logic                wr_en;
    logic                wr_bank;
    logic [AW-1:0]       wr_addr;
    logic [XLEN-1:0]     wr_data;
    logic                iss_valid;
    logic                iss_ready;
    logic [NRD-1:0]      iss_src_used;
    logic                iss_rd_we;
    logic                iss_rd_bank;
    logic [AW-1:0]       iss_rd;
    logic                iss_long;
    logic                flush;
    logic [AW+1:0]       busy_cnt;

    modport master (
        output rd_addr, rd_bank, wr_en, wr_bank, wr_addr, wr_data,
               iss_valid, iss_src_used, iss_rd_we, iss_rd_bank, iss_rd, iss_long, flush,
        input  rd_data, iss_ready, busy_cnt
    );

    modport slave (
        input  rd_addr, rd_bank, wr_en, wr_bank, wr_addr, wr_data,
               iss_valid, iss_src_used, iss_rd_we, iss_rd_bank, iss_rd, iss_long, flush,
        output rd_data, iss_ready, busy_cnt
    );
endinterface

// File: rtl/decode_regbank.sv
// rtl/decode_regbank.sv - GPR/FPR banks with bypassed read ports and long-latency issue scoreboard
module decode_regbank #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = 5,
    parameter int NRD   = 3
) (
    input  logic            clk,
    input  logic            rst,
    decode_regbank_if.slave bus
);
    localparam logic [NREGS-1:0] ONE = NREGS'(1);

    logic [XLEN-1:0]     gpr [NREGS];
    logic [XLEN-1:0]     fpr [NREGS];
    logic [NREGS-1:0]    busy_g, busy_f;
    logic [NREGS-1:0]    clr_g, clr_f, set_g, set_f;
    logic [NREGS-1:0]    eff_g, eff_f;
    logic [NREGS-1:0]    wr_onehot, dst_onehot;
    logic [NRD*XLEN-1:0] rd_data_c;
    logic                src_hit, dst_busy, ready, set_en;
    logic                inc, dec;
    logic [AW+1:0]       cnt_q;

    // x0 is masked out of every write, clear and set so it never holds data or busy state
    assign wr_onehot  = ONE << bus.wr_addr;
    assign dst_onehot = ONE << bus.iss_rd;
    assign clr_g = (bus.wr_en && !bus.wr_bank) ? (wr_onehot & ~ONE) : '0;
    assign clr_f = (bus.wr_en &&  bus.wr_bank) ? wr_onehot : '0;
    assign eff_g = busy_g & ~clr_g;
    assign eff_f = busy_f & ~clr_f;

    always_comb begin
        logic [AW-1:0]   a;
        logic            b;
        logic [XLEN-1:0] v;
        rd_data_c = '0;
        src_hit   = 1'b0;
        for (int i = 0; i < NRD; i++) begin
            a = bus.rd_addr[i*AW +: AW];
            b = bus.rd_bank[i];
            v = b ? fpr[a] : gpr[a];
            if (bus.wr_en && bus.wr_bank == b && bus.wr_addr == a && (b || a != '0))
                v = bus.wr_data;
            rd_data_c[i*XLEN +: XLEN] = v;
            if (bus.iss_src_used[i] && (b ? eff_f[a] : eff_g[a]))
                src_hit = 1'b1;
        end
    end

    assign dst_busy = bus.iss_rd_bank ? eff_f[bus.iss_rd] : eff_g[bus.iss_rd];
    assign ready    = !bus.flush && !src_hit && !(bus.iss_rd_we && dst_busy);
    assign set_en   = bus.iss_valid && ready && bus.iss_rd_we && bus.iss_long;
    assign set_g    = (set_en && !bus.iss_rd_bank) ? (dst_onehot & ~ONE) : '0;
    assign set_f    = (set_en &&  bus.iss_rd_bank) ? dst_onehot : '0;

    // A set on a busy register that is also being cleared leaves the count unchanged
    assign inc = |({set_f, set_g} & ~{busy_f, busy_g});
    assign dec = |({clr_f, clr_g} & {busy_f, busy_g} & ~{set_f, set_g});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                gpr[i] <= '0;
                fpr[i] <= '0;
            end
        end else if (bus.wr_en) begin
            if (bus.wr_bank)
                fpr[bus.wr_addr] <= bus.wr_data;
            else if (bus.wr_addr != '0)
                gpr[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_g <= '0;
            busy_f <= '0;
            cnt_q  <= '0;
        end else if (bus.flush) begin
            busy_g <= '0;
            busy_f <= '0;
            cnt_q  <= '0;
        end else begin
            busy_g <= eff_g | set_g;
            busy_f <= eff_f | set_f;
            case ({inc, dec})
                2'b10:   cnt_q <= cnt_q + (AW+2)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+2)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign bus.rd_data   = rd_data_c;
    assign bus.iss_ready = ready;
    assign bus.busy_cnt  = cnt_q;
endmodule

// File: tb/tb_decode_regbank.sv
// tb/tb_decode_regbank.sv - scoreboard bench for decode_regbank
module tb_decode_regbank;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    decode_regbank_if #(.XLEN(32), .AW(5), .NRD(3)) bus ();
    decode_regbank #(.XLEN(32), .NREGS(32), .AW(5), .NRD(3)) dut (.clk(clk), .rst(rst), .bus(bus));

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] e;
    logic [31:0] mg [32];
    logic [31:0] mf [32];

    task automatic idle();
        bus.rd_addr = '0; bus.rd_bank = '0; bus.wr_en = 0; bus.wr_bank = 0;
        bus.wr_addr = '0; bus.wr_data = '0; bus.iss_valid = 0; bus.iss_src_used = '0;
        bus.iss_rd_we = 0; bus.iss_rd_bank = 0; bus.iss_rd = '0; bus.iss_long = 0; bus.flush = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int p, input logic b, input logic [4:0] a);
        bus.rd_bank[p] = b;
        bus.rd_addr[p*5 +: 5] = a;
    endtask

    task automatic drive_wr(input logic b, input logic [4:0] a, input logic [31:0] d);
        bus.wr_en = 1; bus.wr_bank = b; bus.wr_addr = a; bus.wr_data = d;
        if (b) mf[a] = d;
        else if (a != 0) mg[a] = d;
    endtask

    task automatic long_issue(input logic b, input logic [4:0] a);
        bus.iss_valid = 1; bus.iss_rd_we = 1; bus.iss_long = 1; bus.iss_rd_bank = b; bus.iss_rd = a;
    endtask

    function automatic logic [31:0] model_rd(input logic b, input logic [4:0] a);
        return b ? mf[a] : (a == 0 ? 32'h0 : mg[a]);
    endfunction

    task automatic test_reset();
        idle();
        #2;
        exp_q.push_back(32'd0);
        e = exp_q.pop_front(); checks++;
        if (bus.busy_cnt !== e[6:0]) begin errors++; $display("FAIL por_busy_cnt got %0d want %0d", bus.busy_cnt, e); end
        tick(); tick();
        rst = 0;
        drive_wr(0, 5'd10, 32'hA5A5_0001);
        tick();
        idle();
        long_issue(0, 5'd11);
        tick();
        idle();
        #2;
        rst = 1;
        #1;
        for (int i = 0; i < 32; i++) begin mg[i] = 0; mf[i] = 0; end
        exp_q.push_back(32'd0); exp_q.push_back(32'd1);
        e = exp_q.pop_front(); checks++;
        if (bus.busy_cnt !== e[6:0]) begin errors++; $display("FAIL rst_busy_cnt got %0d want %0d", bus.busy_cnt, e); end
        e = exp_q.pop_front(); checks++;
        if (bus.iss_ready !== e[0]) begin errors++; $display("FAIL rst_ready got %0b want %0b", bus.iss_ready, e[0]); end
        for (int b = 0; b < 2; b++) begin
            set_rd(0, b[0], 5'd10); set_rd(1, b[0], 5'd11); set_rd(2, b[0], 5'd31);
            for (int p = 0; p < 3; p++) exp_q.push_back(32'h0);
            #1;
            for (int p = 0; p < 3; p++) begin
                e = exp_q.pop_front(); checks++;
                if (bus.rd_data[p*32 +: 32] !== e) begin errors++; $display("FAIL rst_read bank %0d port %0d got %h want %h", b, p, bus.rd_data[p*32 +: 32], e); end
            end
        end
        idle();
        tick();
        rst = 0;
        drive_wr(0, 5'd11, 32'h0000_0077);
        tick();
        idle();
        set_rd(0, 0, 5'd11);
        exp_q.push_back(32'd0); exp_q.push_back(32'h77);
        #2;
        e = exp_q.pop_front(); checks++;
        if (bus.busy_cnt !== e[6:0]) begin errors++; $display("FAIL post_rst_wb_cnt got %0d want %0d", bus.busy_cnt, e); end
        e = exp_q.pop_front(); checks++;
        if (bus.rd_data[31:0] !== e) begin errors++; $display("FAIL post_rst_wb_data got %h want %h", bus.rd_data[31:0], e); end
    endtask

    task automatic test_x0();
        tick(); idle();
        drive_wr(0, 5'd0, 32'hDEAD_BEEF);
        tick(); idle();
        drive_wr(1, 5'd0, 32'h3F80_0000);
        tick(); idle();
        set_rd(0, 0, 5'd0); set_rd(1, 1, 5'd0);
        exp_q.push_back(32'h0); exp_q.push_back(32'h3F80_0000);
        #2;
        e = exp_q.pop_front(); checks++;
        if (bus.rd_data[31:0] !== e) begin errors++; $display("FAIL x0_read got %h want %h", bus.rd_data[31:0], e); end
        e = exp_q.pop_front(); checks++;
        if (bus.rd_data[63:32] !== e) begin errors++; $display("FAIL f0_read got %h want %h", bus.rd_data[63:32], e); end
    endtask

    task automatic test_bypass();
        tick(); idle();
        set_rd(0, 0, 5'd5); set_rd(1, 1, 5'd5);
        exp_q.push_back(32'h1234_5678); exp_q.push_back(model_rd(1, 5'd5));
        drive_wr(0, 5'd5, 32'h1234_5678);
        #2;
        e = exp_q.pop_front(); checks++;
        if (bus.rd_data[31:0] !== e) begin errors++; $display("FAIL bypass_x5 got %h want %h", bus.rd_data[31:0], e); end
        e = exp_q.pop_front(); checks++;
        if (bus.rd_data[63:32] !== e) begin errors++; $display("FAIL bypass_bank got %h want %h", bus.rd_data[63:32], e); end
        tick(); idle();
        set_rd(2, 0, 5'd0);
        exp_q.push_back(32'h0);
        drive_wr(0, 5'd0, 32'hFFFF_FFFF);
        #2;
        e = exp_q.pop_front(); checks++;
        if (bus.rd_data[95:64] !== e) begin errors++; $display("FAIL bypass_x0 got %h want %h", bus.rd_data[95:64], e); end
    endtask

    task automatic test_array();
        for (int i = 0; i < 16; i++) begin
            tick(); idle();
            drive_wr(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
        end
        tick(); idle();
        for (int i = 0; i < 5; i++) begin
            for (int p = 0; p < 3; p++) begin
                set_rd(p, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
                exp_q.push_back(model_rd(bus.rd_bank[p], bus.rd_addr[p*5 +: 5]));
            end
            #1;
            for (int p = 0; p < 3; p++) begin
                e = exp_q.pop_front(); checks++;
                if (bus.rd_data[p*32 +: 32] !== e) begin errors++; $display("FAIL array_read port %0d got %h want %h", p, bus.rd_data[p*32 +: 32], e); end
            end
        end
    endtask

    task automatic test_raw();
        tick(); idle();
        long_issue(1, 5'd3);
        exp_q.push_back(32'd1);
        #2;
        e = exp_q.pop_front(); checks++;
        if (bus.iss_ready !== e[0]) begin errors++; $display("FAIL raw_issue_ready got %0b want %0b", bus.iss_ready, e[0]); end
        tick(); idle();
        bus.iss_valid = 1; bus.iss_src_used = 3'b001; set_rd(0, 1, 5'd3);
        exp_q.push_back(32'd0); exp_q.push_back(32'd1);
        #2;
        e = exp_q.pop_front(); checks++;
        if (bus.iss_ready !== e[0]) begin errors++; $display("FAIL raw_stall got %0b want %0b", bus.iss_ready, e[0]); end
        e = exp_q.pop_front(); checks++;
        if (bus.busy_cnt !== e[6:0]) begin errors++; $display("FAIL raw_busy_cnt got %0d want %0d", bus.busy_cnt, e); end
        tick(); tick();
        exp_q.push_back(32'd1); exp_q.push_back(32'hC0FF_EE11);
        drive_wr(1, 5'd3, 32'hC0FF_EE11);
        #2;
        e = exp_q.pop_front(); checks++;
        if (bus.iss_ready !== e[0]) begin errors++; $display("FAIL raw_release got %0b want %0b", bus.iss_ready, e[0]); end
        e = exp_q.pop_front(); checks++;
        if (bus.rd_data[31:0] !== e) begin errors++; $display("FAIL raw_wb_data got %h want %h", bus.rd_data[31:0], e); end
        tick(); idle();
        exp_q.push_back(32'd0);
        #2;
        e = exp_q.pop_front(); checks++;
        if (bus.busy_cnt !== e[6:0]) begin errors++; $display("FAIL raw_cnt_clear got %0d want %0d", bus.busy_cnt, e); end
    endtask

    task automatic test_bank_sep();
        tick(); idle();
        long_issue(1, 5'd3);
        tick(); idle();
        bus.iss_valid = 1; bus.iss_src_used = 3'b010; set_rd(1, 0, 5'd3);
        exp_q.push_back(32'd1);
        #2;
        e = exp_q.pop_front(); checks++;
        if (bus.iss_ready !== e[0]) begin errors++; $display("FAIL bank_sep_ready got %0b want %0b", bus.iss_ready, e[0]); end
        tick(); idle();
        drive_wr(1, 5'd3, 32'h4000_0000);
        tick(); idle();
        exp_q.push_back(32'd0);
        #2;
        e = exp_q.pop_front(); checks++;
        if (bus.busy_cnt !== e[6:0]) begin errors++; $display("FAIL bank_sep_cnt got %0d want %0d", bus.busy_cnt, e); end
    endtask

    task automatic test_collision();
        tick(); idle();
        long_issue(0, 5'd7);
        drive_wr(0, 5'd7, 32'h0000_0707);
        exp_q.push_back(32'd1);
        #2;
        e = exp_q.pop_front(); checks++;
        if (bus.iss_ready !== e[0]) begin errors++; $display("FAIL coll_ready got %0b want %0b", bus.iss_ready, e[0]); end
        tick(); idle();
        bus.iss_src_used = 3'b100; set_rd(2, 0, 5'd7);
        exp_q.push_back(32'd1); exp_q.push_back(32'd0);
        #2;
        e = exp_q.pop_front(); checks++;
        if (bus.busy_cnt !== e[6:0]) begin errors++; $display("FAIL coll_cnt got %0d want %0d", bus.busy_cnt, e); end
        e = exp_q.pop_front(); checks++;
        if (bus.iss_ready !== e[0]) begin errors++; $display("FAIL coll_busy got %0b want %0b", bus.iss_ready, e[0]); end
        tick(); idle();
        drive_wr(0, 5'd7, 32'h0000_0708);
        tick(); idle();
    endtask

    task automatic test_back_to_back();
        tick(); idle();
        long_issue(0, 5'd4);
        tick();
        exp_q.push_back(32'd0); exp_q.push_back(32'd1);
        #2;
        e = exp_q.pop_front(); checks++;
        if (bus.iss_ready !== e[0]) begin errors++; $display("FAIL waw_stall got %0b want %0b", bus.iss_ready, e[0]); end
        e = exp_q.pop_front(); checks++;
        if (bus.busy_cnt !== e[6:0]) begin errors++; $display("FAIL waw_cnt got %0d want %0d", bus.busy_cnt, e); end
        drive_wr(0, 5'd4, 32'h0000_0044);
        exp_q.push_back(32'd1);
        #1;
        e = exp_q.pop_front(); checks++;
        if (bus.iss_ready !== e[0]) begin errors++; $display("FAIL waw_release got %0b want %0b", bus.iss_ready, e[0]); end
        tick(); idle();
        exp_q.push_back(32'd1);
        #2;
        e = exp_q.pop_front(); checks++;
        if (bus.busy_cnt !== e[6:0]) begin errors++; $display("FAIL waw_set_wins got %0d want %0d", bus.busy_cnt, e); end
        drive_wr(0, 5'd4, 32'h0000_0045);
        tick(); idle();
        exp_q.push_back(32'd0);
        #2;
        e = exp_q.pop_front(); checks++;
        if (bus.busy_cnt !== e[6:0]) begin errors++; $display("FAIL waw_cnt_clear got %0d want %0d", bus.busy_cnt, e); end
    endtask

    task automatic test_flush();
        tick(); idle();
        long_issue(0, 5'd1);
        tick(); idle();
        long_issue(1, 5'd2);
        tick(); idle();
        exp_q.push_back(32'd2);
        #2;
        e = exp_q.pop_front(); checks++;
        if (bus.busy_cnt !== e[6:0]) begin errors++; $display("FAIL flush_pre_cnt got %0d want %0d", bus.busy_cnt, e); end
        bus.flush = 1;
        long_issue(0, 5'd9);
        drive_wr(0, 5'd1, 32'h0000_1111);
        exp_q.push_back(32'd0);
        #1;
        e = exp_q.pop_front(); checks++;
        if (bus.iss_ready !== e[0]) begin errors++; $display("FAIL flush_ready got %0b want %0b", bus.iss_ready, e[0]); end
        tick(); idle();
        bus.iss_src_used = 3'b011; set_rd(0, 0, 5'd9); set_rd(1, 1, 5'd2); set_rd(2, 0, 5'd1);
        exp_q.push_back(32'd0); exp_q.push_back(32'd1); exp_q.push_back(32'h1111);
        #2;
        e = exp_q.pop_front(); checks++;
        if (bus.busy_cnt !== e[6:0]) begin errors++; $display("FAIL flush_cnt got %0d want %0d", bus.busy_cnt, e); end
        e = exp_q.pop_front(); checks++;
        if (bus.iss_ready !== e[0]) begin errors++; $display("FAIL flush_cleared got %0b want %0b", bus.iss_ready, e[0]); end
        e = exp_q.pop_front(); checks++;
        if (bus.rd_data[95:64] !== e) begin errors++; $display("FAIL flush_wb_data got %h want %h", bus.rd_data[95:64], e); end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin mg[i] = 0; mf[i] = 0; end
        test_reset();
        test_x0();
        test_bypass();
        test_array();
        test_raw();
        test_bank_sep();
        test_collision();
        test_back_to_back();
        test_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
